// File: rtl/seg7_scan_capture.sv
// Passive monitor for a multiplexed active-low 7-segment bus: waits for the bus
// to settle, then recovers each digit's nibble plus blank / invalid / frame status.
module seg7_scan_capture #(
  parameter int DIGITS = 4,
  parameter int SETTLE = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGITS-1:0]     an_n,
  input  logic [6:0]            seg_n,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     blank,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  bus_err,
  output logic                  frame_valid
);

  localparam int BUS_W = DIGITS + 7;
  localparam logic [3:0] SETTLE_MAX = 4'(SETTLE);
  localparam logic [3:0] SETTLE_HIT = 4'(SETTLE - 1);

  // Returns {valid, nibble}; valid = 0 for any pattern outside the hex font.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b1000000: decode = {1'b1, 4'h0};
      7'b1111001: decode = {1'b1, 4'h1};
      7'b0100100: decode = {1'b1, 4'h2};
      7'b0110000: decode = {1'b1, 4'h3};
      7'b0011001: decode = {1'b1, 4'h4};
      7'b0010010: decode = {1'b1, 4'h5};
      7'b0000010: decode = {1'b1, 4'h6};
      7'b1111000: decode = {1'b1, 4'h7};
      7'b0000000: decode = {1'b1, 4'h8};
      7'b0010000: decode = {1'b1, 4'h9};
      7'b0001000: decode = {1'b1, 4'hA};
      7'b0000011: decode = {1'b1, 4'hB};
      7'b1000110: decode = {1'b1, 4'hC};
      7'b0100001: decode = {1'b1, 4'hD};
      7'b0000110: decode = {1'b1, 4'hE};
      7'b0001110: decode = {1'b1, 4'hF};
      default:    decode = 5'b0_0000;
    endcase
  endfunction

  logic [BUS_W-1:0]  s_q;
  logic [3:0]        cnt;
  logic [DIGITS-1:0] seen;

  logic              sample_p0;
  logic [DIGITS-1:0] sel_p0;
  logic [6:0]        seg_p0;
  logic              one_low_p0;
  logic              multi_low_p0;
  logic [DIGITS-1:0] seen_nxt_p0;
  logic [4:0]        dec_p0;

  // Stage p0: settled bus s_q is classified in the cycle the counter hits its mark
  always_comb begin
    sample_p0    = (cnt == SETTLE_HIT);
    sel_p0       = ~s_q[BUS_W-1:7];
    seg_p0       = s_q[6:0];
    multi_low_p0 = (sel_p0 & (sel_p0 - 1'b1)) != '0;
    one_low_p0   = (sel_p0 != '0) && !multi_low_p0;
    seen_nxt_p0  = seen | sel_p0;
    dec_p0       = decode(seg_p0);
  end

  // Stage p1: registered status and recovered digits
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q         <= '1;
      cnt         <= 4'd0;
      seen        <= '0;
      value       <= '0;
      blank       <= '0;
      digit_err   <= '0;
      bus_err     <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      s_q         <= {an_n, seg_n};
      bus_err     <= 1'b0;
      frame_valid <= 1'b0;
      if ({an_n, seg_n} != s_q)
        cnt <= 4'd0;
      else if (cnt != SETTLE_MAX)
        cnt <= cnt + 4'd1;

      if (sample_p0) begin
        if (multi_low_p0) begin
          bus_err <= 1'b1;
        end else if (one_low_p0) begin
          for (int i = 0; i < DIGITS; i++) begin
            if (sel_p0[i]) begin
              if (seg_p0 == 7'h7F) begin
                blank[i]         <= 1'b1;
                digit_err[i]     <= 1'b0;
                value[4*i +: 4]  <= 4'h0;
              end else if (dec_p0[4]) begin
                blank[i]         <= 1'b0;
                digit_err[i]     <= 1'b0;
                value[4*i +: 4]  <= dec_p0[3:0];
              end else begin
                blank[i]         <= 1'b0;
                digit_err[i]     <= 1'b1;
              end
            end
          end
          // Completing the mask reports the frame and starts the next one at once.
          if (&seen_nxt_p0) begin
            seen        <= '0;
            frame_valid <= 1'b1;
          end else begin
            seen        <= seen_nxt_p0;
          end
        end
      end
    end
  end

endmodule
